// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter for the mouse port. Sends one command byte
// using the request-to-send sequence (inhibit clock, drive start bit, release
// clock, shift bits out on device falling edges) and checks the device ACK.
// Both PS/2 lines are sampled through 2-flop synchronizers and are only ever
// pulled low (open drain); the top level turns *_oe into tri-state drivers,
// so the existing mouse receiver can share the same pins.
//
// Ports
//   clock_100Mhz   system clock (100 MHz)
//   reset          asynchronous, active-high reset
//   tx_data[7:0]   command byte, captured on accept
//   tx_valid       request to send tx_data
//   tx_ready       high only while idle
//   Mouse_Clk_in   raw PS/2 clock pin level
//   Mouse_Data_in  raw PS/2 data pin level
//   Mouse_Clk_oe   1 = pull PS/2 clock low, 0 = release
//   Mouse_Data_oe  1 = pull PS/2 data low, 0 = release
//   tx_done        one-cycle pulse: byte sent and acknowledged
//   tx_error       one-cycle pulse: NACK or timeout
//   fsm_state[2:0] current FSM state (debug visibility)
//
// Handshake: a byte is accepted at a rising clock edge where
// tx_valid & tx_ready are both high. tx_ready is high only in IDLE; tx_valid
// while busy is ignored (nothing is queued). Completion is reported by exactly
// one of tx_done / tx_error, each a single-cycle pulse, in the same cycle that
// tx_ready returns high.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       Mouse_Clk_in,
    input  logic       Mouse_Data_in,
    output logic       Mouse_Clk_oe,
    output logic       Mouse_Data_oe,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] fsm_state
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Synchronizers; reset to 1 (idle bus level) so no false edge after reset.
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       clk_s;
    logic       data_s;
    logic       fall;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], Mouse_Clk_in};
            data_sync <= {data_sync[0], Mouse_Data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;          // inhibit length / inter-event timeout
    logic [3:0]    bit_cnt_q, bit_cnt_d;  // falling edges seen in SEND
    logic [8:0]    frame_q, frame_d;      // {parity, data}
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    k_next;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic. Outputs are registered, so each value
    // computed here appears in the cycle after the deciding condition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        k_next    = bit_cnt_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (tx_valid) begin
                    frame_d  = {~^tx_data, tx_data};
                    state_d  = S_INHIBIT;
                    clk_oe_d = 1'b1;
                end
            end

            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    state_d   = S_REQ;
                    data_oe_d = 1'b1;  // start bit goes down while clock is still held
                end
            end

            S_REQ: begin
                // Release clock, keep the start bit (0) driven.
                state_d   = S_SEND;
                data_oe_d = 1'b1;
                cnt_d     = '0;
                bit_cnt_d = '0;
            end

            S_SEND: begin
                data_oe_d = data_oe_q;
                if (fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = k_next;
                    if (k_next == 4'd10) begin
                        data_oe_d = 1'b0;  // stop bit: release data
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~frame_q[k_next - 4'd1];
                    end
                end else if (cnt_q == TO_LAST) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready      = (state_q == S_IDLE);
    assign Mouse_Clk_oe  = clk_oe_q;
    assign Mouse_Data_oe = data_oe_q;
    assign tx_done       = done_q;
    assign tx_error      = err_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
// Expected frames (start, data LSB first, odd parity, stop) are queued when a
// byte is sent and compared against what the device model sampled.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TO  = 2000;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT connections
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       Mouse_Clk_oe;
    logic       Mouse_Data_oe;
    logic       tx_done;
    logic       tx_error;
    logic [2:0] fsm_state;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       Mouse_Clk_in;
    logic       Mouse_Data_in;

    // Wired-AND bus: either side may pull low.
    assign Mouse_Clk_in  = dev_clk  & ~Mouse_Clk_oe;
    assign Mouse_Data_in = dev_data & ~Mouse_Data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .Mouse_Clk_in (Mouse_Clk_in),
        .Mouse_Data_in(Mouse_Data_in),
        .Mouse_Clk_oe (Mouse_Clk_oe),
        .Mouse_Data_oe(Mouse_Data_oe),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .fsm_state    (fsm_state)
    );

    // Scoreboard
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   both_cnt = 0;
    int   long_cnt = 0;
    logic done_prev = 1'b0;
    logic err_prev  = 1'b0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
        if ((tx_done === 1'b1 && done_prev) || (tx_error === 1'b1 && err_prev))
            long_cnt <= long_cnt + 1;
        done_prev <= (tx_done === 1'b1);
        err_prev  <= (tx_error === 1'b1);
    end

    // Driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Accept a byte and check the request-to-send sequence up to clock release.
    // Returns on the first negedge where the clock is released.
    task automatic send_start(input logic [7:0] d);
        int   cyc;
        logic clk_drop;
        @(negedge clk);
        check("ready_before", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        exp_q.push_back({1'b1, ~^d, d, 1'b0});
        check("clk_oe_after_accept", Mouse_Clk_oe, 1);
        check("ready_busy", tx_ready, 0);
        cyc      = 0;
        clk_drop = 1'b0;
        while (Mouse_Data_oe !== 1'b1 && cyc < INH + 20) begin
            @(negedge clk);
            cyc++;
            if (Mouse_Clk_oe !== 1'b1) clk_drop = 1'b1;
        end
        check("inhibit_len", cyc, INH);
        check("clk_held", clk_drop, 0);
        check("req_clk_low", Mouse_Clk_oe, 1);
        @(negedge clk);
        check("clk_release", Mouse_Clk_oe, 0);
        check("start_driven", Mouse_Data_oe, 1);
    endtask

    // Device model: samples start on clock release, then one bit per rising
    // edge for n_pulses pulses (max 10); pulse 11 is the ACK clock.
    task automatic dev_frame(input int n_pulses, input bit ack_low, output logic [10:0] s);
        int w;
        s = '0;
        w = 0;
        while (Mouse_Clk_oe !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("dev_release_seen", Mouse_Clk_oe, 0);
        wait_cycles(10);
        s[0] = Mouse_Data_in;
        for (int i = 1; i <= n_pulses && i <= 10; i++) begin
            dev_clk = 1'b0;
            wait_cycles(20);
            dev_clk = 1'b1;
            s[i] = Mouse_Data_in;
            wait_cycles(20);
        end
        if (n_pulses >= 11) begin
            if (ack_low) dev_data = 1'b0;
            wait_cycles(5);
            dev_clk = 1'b0;
            wait_cycles(20);
            dev_clk = 1'b1;
            wait_cycles(5);
            dev_data = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_clk_oe"}, Mouse_Clk_oe, 0);
        check({tag, "_data_oe"}, Mouse_Data_oe, 0);
        check({tag, "_ready"}, tx_ready, 1);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    logic [10:0] s;
    logic [10:0] e;
    int          d0, e0, cyc;
    logic        requeued;

    initial begin
        // Power-up reset
        @(negedge clk);
        #1;
        check_idle("por");
        check("por_done", tx_done, 0);
        check("por_err", tx_error, 0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(5);
        check("por_no_pulses", done_cnt + err_cnt, 0);

        // Reset asserted while idle
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_idle("idle_rst");
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(3);

        // 0xF4, device ACKs
        d0 = done_cnt; e0 = err_cnt;
        send_start(8'hF4);
        dev_frame(11, 1'b1, s);
        e = exp_q.pop_front();
        check("frame_f4", s, e);
        check("frame_f4_bits", s, 11'b1_0_11110100_0);
        wait_cycles(20);
        check("f4_done", done_cnt - d0, 1);
        check("f4_err", err_cnt - e0, 0);
        check_idle("f4_end");

        // 0xFF, device ACKs; a 0x00 request mid-frame must be ignored
        d0 = done_cnt; e0 = err_cnt;
        send_start(8'hFF);
        fork
            dev_frame(11, 1'b1, s);
            begin
                wait_cycles(100);
                check("ff_ready_mid", tx_ready, 0);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        e = exp_q.pop_front();
        check("frame_ff", s, e);
        check("ff_parity", s[9], 1);
        wait_cycles(20);
        check("ff_done", done_cnt - d0, 1);
        check("ff_err", err_cnt - e0, 0);
        requeued = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (Mouse_Clk_oe !== 1'b0 || tx_ready !== 1'b1) requeued = 1'b1;
        end
        check("ff_no_requeue", requeued, 0);

        // NACK: device leaves data high at the 11th fall
        d0 = done_cnt; e0 = err_cnt;
        send_start(8'h3C);
        dev_frame(11, 1'b0, s);
        e = exp_q.pop_front();
        check("frame_nack", s, e);
        wait_cycles(20);
        check("nack_err", err_cnt - e0, 1);
        check("nack_done", done_cnt - d0, 0);
        check_idle("nack_end");

        // Device never clocks: timeout counted from clock release
        d0 = done_cnt; e0 = err_cnt;
        send_start(8'hF4);
        e = exp_q.pop_front();
        cyc = 0;
        while (tx_error !== 1'b1 && cyc < TO + 50) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_len", cyc, TO);
        check("timeout_clk_oe", Mouse_Clk_oe, 0);
        check("timeout_data_oe", Mouse_Data_oe, 0);
        wait_cycles(5);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_done", done_cnt - d0, 0);
        check_idle("timeout_end");

        // Reset after the 4th falling edge
        d0 = done_cnt; e0 = err_cnt;
        send_start(8'hF4);
        dev_frame(4, 1'b1, s);
        e = exp_q.pop_front();
        check("partial_bits", s[4:0], e[4:0]);
        check("drv_bit3", Mouse_Data_oe, 1);
        #2 reset = 1'b1;
        #1 check_idle("mid_rst");
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(30);
        check("mid_rst_done", done_cnt - d0, 0);
        check("mid_rst_err", err_cnt - e0, 0);

        // Normal send after the aborted one
        d0 = done_cnt; e0 = err_cnt;
        send_start(8'hF4);
        dev_frame(11, 1'b1, s);
        e = exp_q.pop_front();
        check("frame_after_rst", s, e);
        wait_cycles(20);
        check("after_rst_done", done_cnt - d0, 1);
        check("after_rst_err", err_cnt - e0, 0);

        // Final report
        check("pulse_width", long_cnt, 0);
        check("done_err_overlap", both_cnt, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
